// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a show-ahead FIFO into a valid/ready stream with packet
//            framing (m_last) through a 2-entry output buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  busy
);

    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_last0;
    logic                  r_last1;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_flush_pend;
    logic [CNT_WIDTH-1:0]  r_words;

    logic                  w_pop;
    logic                  w_acc;
    logic [LEN_WIDTH-1:0]  w_len_req;
    logic [LEN_WIDTH-1:0]  w_len_cur;
    logic                  w_flush_now;
    logic                  w_last_in;
    logic                  w_wr_idx;

    // Pop decision uses only registered occupancy, never m_ready.
    assign w_pop       = !reset && enable && !fifo_empty && (r_occ < 2'd2);
    assign w_acc       = (r_occ != 2'd0) && m_ready;
    assign w_len_req   = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    assign w_len_cur   = (r_beat == '0) ? w_len_req : r_len;
    assign w_flush_now = flush && (r_beat != '0);
    assign w_last_in   = (r_beat == w_len_cur - LEN_WIDTH'(1)) || r_flush_pend || w_flush_now;
    // Tail slot after any same-cycle head removal.
    assign w_wr_idx    = (r_occ == 2'd1) && !w_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ   <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            if (w_acc) begin
                r_data0 <= r_data1;
                r_last0 <= r_last1;
            end
            if (w_pop) begin
                if (w_wr_idx) begin
                    r_data1 <= fifo_rd_data;
                    r_last1 <= w_last_in;
                end else begin
                    r_data0 <= fifo_rd_data;
                    r_last0 <= w_last_in;
                end
            end
            r_occ <= r_occ + {1'b0, w_pop} - {1'b0, w_acc};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat       <= '0;
            r_len        <= LEN_WIDTH'(1);
            r_flush_pend <= 1'b0;
        end else if (w_pop) begin
            if (r_beat == '0) begin
                r_len <= w_len_req;
            end
            r_beat       <= w_last_in ? '0 : r_beat + LEN_WIDTH'(1);
            r_flush_pend <= 1'b0;
        end else if (w_flush_now) begin
            r_flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_words <= '0;
        end else if (w_acc) begin
            r_words <= r_words + CNT_WIDTH'(1);
        end
    end

    assign fifo_rd_en = w_pop;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = m_valid ? r_data0 : '0;
    assign m_last     = m_valid && r_last0;
    assign words_out  = r_words;
    assign busy       = (r_occ != 2'd0) || (r_beat != '0);

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Directed, table-driven bench for fifo_stream_reader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int CW = 4;

    typedef struct {
        int          len;
        int          nw;
        logic [31:0] base;
        logic [15:0] ready_pat;
        logic [15:0] exp_last;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [LW-1:0] pkt_len;
    logic          flush;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic [CW-1:0] words_out;
    logic          busy;

    fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pkt_len(pkt_len), .flush(flush),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .words_out(words_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [DW-1:0] mem [0:255];
    logic [7:0]    rp = 8'd0;
    logic [7:0]    wp = 8'd0;
    assign fifo_rd_data = mem[rp];
    assign fifo_empty   = (rp == wp);
    always @(posedge clk) if (fifo_rd_en) rp <= rp + 8'd1;

    // Beat collector and protocol observers
    logic [DW-1:0] got_data [0:255];
    logic          got_last [0:255];
    int            got_cyc  [0:255];
    int            got_n = 0;
    int            cyc = 0;
    int            tb_occ = 0;
    int            viol_rd = 0;
    int            viol_valid = 0;
    int            viol_stall = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            tb_occ     = 0;
            prev_stall = 1'b0;
        end else begin
            if (tb_occ == 2 && fifo_rd_en) viol_rd++;
            if (m_valid != (tb_occ != 0)) viol_valid++;
            if (prev_stall && m_data !== prev_data) viol_stall++;
            if (m_valid && m_ready && got_n < 256) begin
                got_data[got_n] = m_data;
                got_last[got_n] = m_last;
                got_cyc[got_n]  = cyc;
                got_n++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            tb_occ     = tb_occ + int'(fifo_rd_en) - int'(m_valid && m_ready);
        end
        cyc++;
    end

    int   n_pass = 0;
    int   n_total = 0;
    int   exp_acc = 0;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = base + 32'(i);
            wp = wp + 8'd1;
        end
    endtask

    task automatic drain(input int n, input logic [15:0] pat, input string name);
        int target;
        int start;
        start  = got_n;
        target = got_n + n;
        for (int c = 0; c < 300 && got_n < target; c++) begin
            m_ready = pat[c % 16];
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        check({name, "_count"}, 32'(got_n - start), 32'(n));
        exp_acc += n;
        check({name, "_words_out"}, 32'(words_out), 32'(exp_acc % 16));
        check({name, "_rd_en_full"}, 32'(viol_rd), 32'd0);
        check({name, "_valid_occ"}, 32'(viol_valid), 32'd0);
        check({name, "_stall_hold"}, 32'(viol_stall), 32'd0);
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [31:0] d, input logic l);
        check({name, "_data"}, got_data[idx], d);
        check({name, "_last"}, 32'(got_last[idx]), 32'(l));
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic run_vec(input int k);
        int s;
        s = got_n;
        pkt_len = vecs[k].len[LW-1:0];
        push(vecs[k].base, vecs[k].nw);
        m_ready = vecs[k].ready_pat[0];
        @(posedge clk); #1;
        check($sformatf("v%0d_first_latency", k), 32'(m_valid), 32'd1);
        drain(vecs[k].nw, vecs[k].ready_pat, $sformatf("v%0d", k));
        for (int i = 0; i < vecs[k].nw; i++)
            chk_beat($sformatf("v%0d_b%0d", k, i), s + i, vecs[k].base + 32'(i), vecs[k].exp_last[i]);
        if (vecs[k].ready_pat == 16'hFFFF)
            check($sformatf("v%0d_no_bubble", k), 32'(got_cyc[s + vecs[k].nw - 1] - got_cyc[s]),
                  32'(vecs[k].nw - 1));
        check($sformatf("v%0d_idle_busy", k), 32'(busy), 32'd0);
    endtask

    initial begin
        int s;
        vecs[0] = '{4, 8, 32'h10, 16'hFFFF, 16'h0088};
        vecs[1] = '{3, 6, 32'h20, 16'h9999, 16'h0024};
        vecs[2] = '{0, 3, 32'h30, 16'hFFFF, 16'h0007};
        vecs[3] = '{1, 2, 32'h40, 16'h5555, 16'h0003};
        vecs[4] = '{5, 5, 32'h50, 16'h00F3, 16'h0010};

        reset = 1'b1; enable = 1'b1; pkt_len = 8'd4; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_words", 32'(words_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) run_vec(k);

        // Flush: idle flush ignored, then mid-packet flush closes the packet
        pkt_len = 8'd8;
        pulse_flush();
        s = got_n;
        push(32'h60, 3);
        drain(3, 16'hFFFF, "fl_a");
        check("fl_open_busy", 32'(busy), 32'd1);
        pulse_flush();
        push(32'h63, 2);
        drain(2, 16'hFFFF, "fl_b");
        push(32'h65, 7);
        drain(7, 16'hFFFF, "fl_c");
        for (int i = 0; i < 12; i++)
            chk_beat($sformatf("fl_b%0d", i), s + i, 32'h60 + 32'(i), (i == 3) || (i == 11));
        check("fl_done_busy", 32'(busy), 32'd0);

        // Length changes only take effect at a packet boundary
        s = got_n;
        pkt_len = 8'd4;
        push(32'h70, 2);
        drain(2, 16'hFFFF, "ln_a");
        pkt_len = 8'd2;
        push(32'h72, 6);
        drain(6, 16'hFFFF, "ln_b");
        for (int i = 0; i < 8; i++)
            chk_beat($sformatf("ln_b%0d", i), s + i, 32'h70 + 32'(i), (i == 3) || (i == 5) || (i == 7));

        // enable low mid-packet: buffered words drain, no new pops
        s = got_n;
        pkt_len = 8'd4;
        push(32'h80, 6);
        repeat (2) begin @(posedge clk); #1; end
        check("en_full_valid", 32'(m_valid), 32'd1);
        check("en_full_rd_en", 32'(fifo_rd_en), 32'd0);
        enable = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("en_off_rd_en%0d", i), 32'(fifo_rd_en), 32'd0);
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        exp_acc += 2;
        check("en_off_count", 32'(got_n - s), 32'd2);
        check("en_off_valid", 32'(m_valid), 32'd0);
        check("en_off_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        drain(4, 16'hFFFF, "en_on");
        pulse_flush();
        push(32'h86, 1);
        drain(1, 16'hFFFF, "en_fl");
        for (int i = 0; i < 7; i++)
            chk_beat($sformatf("en_b%0d", i), s + i, 32'h80 + 32'(i), (i == 3) || (i == 6));
        check("en_done_busy", 32'(busy), 32'd0);

        // Reset with a full buffer
        pkt_len = 8'd4;
        push(32'h90, 4);
        repeat (2) begin @(posedge clk); #1; end
        check("rm_pre_valid", 32'(m_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rm_valid", 32'(m_valid), 32'd0);
        check("rm_data", m_data, 32'd0);
        check("rm_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rm_words", 32'(words_out), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        wp = rp;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_acc = 0;
        m_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rm_post_valid", 32'(m_valid), 32'd0);
        check("rm_post_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rm_post_words", 32'(words_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Drain-side companion to the team's synchronous FIFO. Pops words from a show-ahead FIFO read port (rd_en/rd_data/empty) and presents them on a valid/ready output stream, framed into packets with a last flag. Contains a 2-entry output buffer so the FIFO pop never depends combinationally on downstream ready. Sits between a FIFO instance and any stream consumer (DMA, serializer).

Parameters:
DATA_WIDTH, 32, width of FIFO words and output data
LEN_WIDTH, 8, width of packet-length input and beat counter
CNT_WIDTH, 16, width of wrapping output-word statistics counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = pops permitted; 0 = stop popping, buffered words still drain
pkt_len  input  LEN_WIDTH  words per packet, sampled when a packet's first word is popped; 0 treated as 1
flush  input  1  single-cycle request to close the open partial packet
fifo_rd_data  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  pop strobe to FIFO
m_valid  output  1  output word valid
m_data  output  DATA_WIDTH  output word
m_last  output  1  final word of packet
m_ready  input  1  consumer accepts when m_valid && m_ready
words_out  output  CNT_WIDTH  count of accepted output beats, wraps
busy  output  1  buffer non-empty or packet open

Behaviour:
- Reset (async, active-high): buffer emptied (data discarded), occupancy=0, beat counter=0, latched length=1, flush-pending=0, words_out=0. While reset is high: m_valid=0, m_last=0, m_data=0, fifo_rd_en=0, busy=0.
- Pop rule: fifo_rd_en = enable && !fifo_empty && (occupancy < 2), computed only from inputs enable/fifo_empty and registered state; no combinational path from m_ready. Pop happens on the edge where fifo_rd_en=1; fifo_rd_data captured into buffer tail on that edge.
- Buffer: 2 entries {data, last}, FIFO order. m_valid = occupancy != 0; m_data/m_last = head entry. m_data=0 when m_valid=0. Pop and accept in the same cycle: occupancy unchanged. Steady state with m_ready=1 and FIFO non-empty: one word per cycle, zero bubbles; first word appears on m_valid 1 cycle after first pop.
- Stall: m_valid and head stable until accepted (m_ready=1). Occupancy 2 -> fifo_rd_en=0.
- Framing: beat counter counts popped words in the current packet. On a pop with beat counter=0, latched length L = max(pkt_len,1). Popped word gets last=1 when beat counter == L-1 (beat counter then returns to 0), else counter increments. L=1 -> every word last.
- Flush: flush=1 with beat counter != 0 sets flush-pending (or, if a pop occurs that same cycle, marks that word last directly). While pending, next popped word gets last=1, counter->0, pending cleared. Flush with beat counter=0 and no pop that cycle: ignored. A word reaching L-1 while pending: last=1, pending cleared (single termination).
- enable=0 mid-packet: popping stops, packet stays open, counter retained; resumes on enable=1.
- words_out increments on each m_valid && m_ready, wraps from 2^CNT_WIDTH-1 to 0.
- busy = (occupancy != 0) || (beat counter != 0).

Test Plan:
- Reset/idle: reset high mid-transfer with occupancy 2 -> next cycle m_valid=0, fifo_rd_en=0, words_out=0; after release, FIFO empty -> outputs stay 0.
- Streaming: pkt_len=4, FIFO holds 0x10..0x17, m_ready=1 -> 8 consecutive beats 0x10..0x17, m_last on 0x13 and 0x17, words_out=8, no idle cycles after first.
- Backpressure: pkt_len=3, 6 words, m_ready toggled 1,0,0,1,... -> order preserved, no loss/duplication, fifo_rd_en=0 whenever occupancy=2, m_data stable while stalled, last on beats 3 and 6.
- Flush: pkt_len=8, pop 3 words, pulse flush, 2 more words -> 4th word carries m_last, 5th starts new packet (last on its 8th word); flush with counter=0 -> no effect.
- Edge lengths: pkt_len=0 -> every word last; pkt_len changed mid-packet from 4 to 2 -> current packet still 4 words, next packet 2.
- Counter wrap: CNT_WIDTH=4, 18 accepted beats -> words_out=2; enable=0 for 5 cycles mid-packet -> no pops, buffered words drain, framing continues correctly.
